// File: rtl/fetch_stage.sv
// fetch_stage
//   Y86-64 fetch stage. Owns the program counter, decodes the combinational
//   instruction-memory response for the current PC and registers one decoded
//   instruction per accepted cycle toward decode. Status is sticky: once a
//   halt, invalid instruction or address error is fetched, fetching stops
//   until reset.
//
//   State | Meaning
//   ------+-------------------------------------------------------------
//   RUN   | fetching; redirect > stall > accept
//   STOP  | non-AOK instruction fetched; everything frozen until reset
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   o_pc                    PC driven to instruction memory
//   i_byte0, i_byte19       memory bytes pc and pc+1..pc+9 (pc+1 in [71:64])
//   i_imem_error            current PC is out of range
//   i_stall                 hold PC and outputs
//   i_pc_load, i_pc_next    redirect request and target
//   o_f_valid               one-cycle pulse per accepted fetch
//   o_icode/o_ifun/o_ra/o_rb, o_valc, o_valp  registered instruction fields
//   o_stat                  1=AOK 2=HLT 3=ADR 4=INS
//   o_instr_count           accepted fetches, wraps modulo 2^64
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [63:0] o_pc,
  input  logic [7:0]  i_byte0,
  input  logic [71:0] i_byte19,
  input  logic        i_imem_error,
  input  logic        i_stall,
  input  logic        i_pc_load,
  input  logic [63:0] i_pc_next,
  output logic        o_f_valid,
  output logic [3:0]  o_icode,
  output logic [3:0]  o_ifun,
  output logic [3:0]  o_ra,
  output logic [3:0]  o_rb,
  output logic [63:0] o_valc,
  output logic [63:0] o_valp,
  output logic [2:0]  o_stat,
  output logic [63:0] o_instr_count
);

  localparam logic S_RUN  = 1'b0;
  localparam logic S_STOP = 1'b1;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  logic        r_state;
  logic [63:0] r_pc;
  logic        r_f_valid;
  logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
  logic [63:0] r_valc, r_valp;
  logic [2:0]  r_stat;
  logic [63:0] r_instr_count;

  logic [3:0]  w_icode, w_ifun, w_ra, w_rb;
  logic        w_need_regids, w_need_valc, w_instr_valid;
  logic [63:0] w_valc_src, w_valc, w_valp;
  logic [2:0]  w_stat;

  always_comb begin
    w_icode = i_byte0[7:4];
    w_ifun  = i_byte0[3:0];

    w_need_regids = (w_icode == 4'h2) || (w_icode == 4'h3) || (w_icode == 4'h4) ||
                    (w_icode == 4'h5) || (w_icode == 4'h6) || (w_icode == 4'hA) ||
                    (w_icode == 4'hB);
    w_need_valc   = (w_icode == 4'h3) || (w_icode == 4'h4) || (w_icode == 4'h5) ||
                    (w_icode == 4'h7) || (w_icode == 4'h8);

    w_ra = w_need_regids ? i_byte19[71:68] : 4'hF;
    w_rb = w_need_regids ? i_byte19[67:64] : 4'hF;

    // The constant starts one byte later when a register-specifier byte is present.
    w_valc_src = w_need_regids ? i_byte19[63:0] : i_byte19[71:8];
    w_valc = '0;
    if (w_need_valc) begin
      for (int k = 0; k < 8; k++) begin
        w_valc[8*k +: 8] = w_valc_src[56-8*k +: 8];
      end
    end

    w_valp = r_pc + 64'd1 + {63'd0, w_need_regids} + (w_need_valc ? 64'd8 : 64'd0);

    case (w_icode)
      4'h2, 4'h7: w_instr_valid = (w_ifun <= 4'd6);
      4'h6:       w_instr_valid = (w_ifun <= 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                  w_instr_valid = (w_ifun == 4'd0);
      default:    w_instr_valid = 1'b0;
    endcase

    if (i_imem_error)        w_stat = STAT_ADR;
    else if (!w_instr_valid) w_stat = STAT_INS;
    else if (w_icode == 4'h0) w_stat = STAT_HLT;
    else                     w_stat = STAT_AOK;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_f_valid     <= 1'b0;
      r_icode       <= '0;
      r_ifun        <= '0;
      r_ra          <= '0;
      r_rb          <= '0;
      r_valc        <= '0;
      r_valp        <= '0;
      r_stat        <= STAT_AOK;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_pc_load) begin
            r_pc      <= i_pc_next;
            r_f_valid <= 1'b0;
          end else if (i_stall) begin
            r_f_valid <= 1'b0;
          end else begin
            r_f_valid     <= 1'b1;
            r_icode       <= w_icode;
            r_ifun        <= w_ifun;
            r_ra          <= w_ra;
            r_rb          <= w_rb;
            r_valc        <= w_valc;
            r_valp        <= w_valp;
            r_stat        <= w_stat;
            r_instr_count <= r_instr_count + 64'd1;
            if (w_stat == STAT_AOK) r_pc    <= w_valp;
            else                    r_state <= S_STOP;
          end
        end
        default: begin
          r_f_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_f_valid     = r_f_valid;
  assign o_icode       = r_icode;
  assign o_ifun        = r_ifun;
  assign o_ra          = r_ra;
  assign o_rb          = r_rb;
  assign o_valc        = r_valc;
  assign o_valp        = r_valp;
  assign o_stat        = r_stat;
  assign o_instr_count = r_instr_count;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Sequential Y86-64 fetch stage that owns the program counter and consumes the instruction-memory response. It drives `pc` to `instruction_memory`, splits the returned `Byte0`/`Byte19` into `icode`/`ifun`/`rA`/`rB`/`valC`, and computes `valP`. It registers one decoded instruction per accepted cycle toward decode. It also tracks processor status and stops fetching permanently on halt, invalid instruction or address error.

## Interface
- `RESET_PC`, default 64'd0: PC value loaded on reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; dominates every other input.
- `pc`  out  64  current PC register, driven to instruction memory.
- `Byte0`  in  8  memory byte at `pc`.
- `Byte19`  in  72  memory bytes `pc+1`..`pc+9`; `[71:64]` = `pc+1`, `[7:0]` = `pc+9`.
- `imem_error`  in  1  address out of range for current `pc`.
- `stall`  in  1  hold PC and output registers.
- `pc_load`  in  1  redirect: squash the current fetch and load `pc_next`.
- `pc_next`  in  64  redirect target.
- `f_valid`  out  1  registered fields hold a newly fetched instruction (one-cycle pulse per fetch).
- `icode`, `ifun`, `rA`, `rB`  out  4 each  registered instruction fields.
- `valC`  out  64  registered constant word.
- `valP`  out  64  registered fall-through PC.
- `stat`  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS; sticky once non-AOK.
- `instr_count`  out  64  number of accepted fetches.

## Operation
- Combinational decode of the current `pc` response:
  - `icode=Byte0[7:4]`, `ifun=Byte0[3:0]`.
  - `need_regids` = icode ∈ {2,3,4,5,6,A,B}.
  - `need_valC` = icode ∈ {3,4,5,7,8}.
  - If `need_regids`: `rA=Byte19[71:68]`, `rB=Byte19[67:64]`, and `valC` is little-endian over `Byte19[63:0]`, so `valC[7:0]=Byte19[63:56]` and so on up to `valC[63:56]=Byte19[7:0]`.
  - Otherwise: `rA=rB=4'hF`, and `valC` is little-endian over `Byte19[71:8]`.
  - If `need_valC=0`, `valC=0`.
  - `valP = pc + 1 + need_regids + 8*need_valC`, truncated to 64 bits (wrap-around allowed).
- Instruction is valid when icode ≤ B and ifun is within range:
  - icode 2 or 7: ifun 0–6.
  - icode 6: ifun 0–3.
  - all other icodes: ifun 0.
- Status priority: `imem_error` → ADR, else invalid → INS, else icode 0 → HLT, else AOK.
- FSM states RUN and STOP. Reset enters RUN with `pc=RESET_PC`, `stat=1`, all field outputs 0, `f_valid=0`, `instr_count=0`.
- Each cycle in RUN, the first matching rule applies:
  1. `pc_load`: `pc<=pc_next`, `f_valid<=0`, output fields hold. Redirect wins over `stall`.
  2. `stall`: everything holds, `f_valid<=0`.
  3. Otherwise accept: register fields and `valP`, `f_valid<=1`, `instr_count+=1`, `stat<=`computed status.
     - If the status is AOK: `pc<=valP`, stay in RUN.
     - If the status is non-AOK: `pc` holds, go to STOP.
- STOP: `pc`, fields, `stat` and `instr_count` all frozen; `f_valid=0`. `pc_load` and `stall` are ignored. Only `reset` leaves STOP.
- The HLT, INS and ADR instructions themselves are presented once with `f_valid=1`. `valP` for an ADR fetch is still computed from `pc`.

## Timing
- Instruction memory is combinational in `pc`, so the response for the PC in cycle N is registered at the end of cycle N. Fields and `f_valid` are visible in cycle N+1 (1-cycle latency).
- Throughput is one instruction per cycle when `stall=0` and `pc_load=0`.
- A redirect costs one bubble: `pc_next` is fetched in the cycle after `pc_load`.
- Reset asserted mid-run or in STOP: on the next edge, all state returns to reset values regardless of `stall` or `pc_load`.
- `instr_count` wraps modulo 2^64.

## Test plan
- Reset, memory at `pc=0` returns `Byte0=0x30`, `Byte19=0xF8_08_00…00` → next cycle: `f_valid=1`, icode 3, ifun 0, rA F, rB 8, `valC=8`, `valP=10`, `pc=10`, stat 1.
- `pc=20` with `Byte0=0x80`, `Byte19[71:8]=0` → icode 8, rA=rB=F, `valC=0`, `valP=29`. Then assert `pc_load` with `pc_next=154` → `f_valid=0`, `pc=154`. Next fetch `Byte0=0x90` → `valP=155`.
- `Byte0=0x00` at `pc=111` → `f_valid=1` once, stat 2, `pc` stays 111. Toggling `pc_load`/`stall` afterwards leaves all outputs frozen; `instr_count` is unchanged.
- `Byte0=0x65` (OPq, ifun 5) → stat 4, STOP. In a separate run, `Byte0=0xC0` → stat 4.
- `imem_error=1` together with `Byte0=0x00` → stat 3 (ADR beats HLT), STOP.
- `stall=1` for 3 cycles mid-stream → `pc`, fields and `instr_count` hold and `f_valid=0`. Then assert `reset` during STOP → `pc=0`, stat 1, `instr_count=0` on the next edge.
